// File: rtl/vip_filter_frame_ctrl_if.sv
// Signal bundle between the register/stream side (master) and vip_filter_frame_ctrl (slave).
// cfg handshake: cfg_req is a one-cycle valid strobe with no ready; cfg_busy flags an unapplied request, cfg_ack strobes once when it takes effect.
interface vip_filter_frame_ctrl_if;
    logic        per_frame_vsync;
    logic        post_frame_vsync;
    logic        post_frame_href;
    logic        post_frame_clken;
    logic        cfg_req;
    logic [1:0]  cfg_mode;
    logic        cfg_ack;
    logic        cfg_busy;
    logic [1:0]  in_mode;
    logic [1:0]  out_sel;
    logic        frame_done;
    logic        err_hsize;
    logic        err_vsize;
    logic        err_clr;
    logic [15:0] frame_cnt;
    logic [1:0]  dbg_meas_state;

    modport master (
        output per_frame_vsync, post_frame_vsync, post_frame_href, post_frame_clken,
        output cfg_req, cfg_mode, err_clr,
        input  cfg_ack, cfg_busy, in_mode, out_sel, frame_done,
        input  err_hsize, err_vsize, frame_cnt, dbg_meas_state
    );

    modport slave (
        input  per_frame_vsync, post_frame_vsync, post_frame_href, post_frame_clken,
        input  cfg_req, cfg_mode, err_clr,
        output cfg_ack, cfg_busy, in_mode, out_sel, frame_done,
        output err_hsize, err_vsize, frame_cnt, dbg_meas_state
    );
endinterface

// File: rtl/vip_filter_frame_ctrl.sv
// Frame-synchronous mode control and output-geometry checker for the 3x3 mean-filter stage.
// Define VIP_FRAME_CTRL_FRAME_CNT_EN to build the 16-bit completed-frame counter; otherwise frame_cnt is 0.
module vip_filter_frame_ctrl #(
    parameter logic [9:0] IMG_HDISP = 10'd640,
    parameter logic [9:0] IMG_VDISP = 10'd480
) (
    input  logic                    clk,
    input  logic                    rst_n,
    vip_filter_frame_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_CHECK  = 2'd2,
        S_WAIT   = 2'd3
    } meas_state_t;

    logic per_vs_d, post_vs_d, href_d;
    logic per_rise, post_rise, post_fall, href_fall;

    // Vsync history resets high so a stream already mid-frame at reset release is not seen as a frame start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            per_vs_d  <= 1'b1;
            post_vs_d <= 1'b1;
            href_d    <= 1'b0;
        end else begin
            per_vs_d  <= bus.per_frame_vsync;
            post_vs_d <= bus.post_frame_vsync;
            href_d    <= bus.post_frame_href;
        end
    end

    assign per_rise  = bus.per_frame_vsync & ~per_vs_d;
    assign post_rise = bus.post_frame_vsync & ~post_vs_d;
    assign post_fall = ~bus.post_frame_vsync & post_vs_d;
    assign href_fall = ~bus.post_frame_href & href_d;

    logic [1:0] pend_mode, in_mode_q, apply_mode, push_mode;
    logic       busy_q, ack_q, apply;

    assign apply      = per_rise & (busy_q | bus.cfg_req);
    assign apply_mode = bus.cfg_req ? bus.cfg_mode : pend_mode;
    assign push_mode  = apply ? apply_mode : in_mode_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_mode <= 2'd0;
            in_mode_q <= 2'd0;
            busy_q    <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            ack_q <= apply;
            if (apply) begin
                in_mode_q <= apply_mode;
                busy_q    <= 1'b0;
            end else if (bus.cfg_req) begin
                pend_mode <= bus.cfg_mode;
                busy_q    <= 1'b1;
            end
        end
    end

    // Two-deep mode FIFO; entry 0 is the oldest, a push into a full FIFO drops it.
    logic [1:0] fifo_q [2];
    logic [1:0] fifo_cnt;
    logic [1:0] out_sel_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_q[0] <= 2'd0;
            fifo_q[1] <= 2'd0;
            fifo_cnt  <= 2'd0;
            out_sel_q <= 2'd0;
        end else begin
            case ({per_rise, post_rise})
                2'b10: begin
                    if (fifo_cnt == 2'd2) begin
                        fifo_q[0] <= fifo_q[1];
                        fifo_q[1] <= push_mode;
                    end else begin
                        fifo_q[fifo_cnt[0]] <= push_mode;
                        fifo_cnt            <= fifo_cnt + 2'd1;
                    end
                end
                2'b01: begin
                    if (fifo_cnt != 2'd0) begin
                        out_sel_q <= fifo_q[0];
                        fifo_q[0] <= fifo_q[1];
                        fifo_cnt  <= fifo_cnt - 2'd1;
                    end
                end
                2'b11: begin
                    case (fifo_cnt)
                        2'd0: out_sel_q <= push_mode;
                        2'd1: begin
                            out_sel_q <= fifo_q[0];
                            fifo_q[0] <= push_mode;
                        end
                        default: begin
                            out_sel_q <= fifo_q[0];
                            fifo_q[0] <= fifo_q[1];
                            fifo_q[1] <= push_mode;
                        end
                    endcase
                end
                default: ;
            endcase
        end
    end

    meas_state_t state_q, state_d;
    logic        cnt_clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // A vsync rise while ACTIVE means the fall was missed: restart counting without a check.
    always_comb begin
        state_d = state_q;
        cnt_clr = 1'b0;
        case (state_q)
            S_IDLE, S_WAIT: begin
                if (post_rise) begin
                    state_d = S_ACTIVE;
                    cnt_clr = 1'b1;
                end
            end
            S_ACTIVE: begin
                if (post_rise)      cnt_clr = 1'b1;
                else if (post_fall) state_d = S_CHECK;
            end
            S_CHECK: state_d = S_WAIT;
            default: state_d = S_IDLE;
        endcase
    end

    logic [10:0] pix_cnt, line_cnt;
    logic        line_end, hsize_bad, vsize_bad;
    logic        err_h_q, err_v_q;

    assign line_end  = (state_q == S_ACTIVE) && !post_rise && href_fall;
    assign hsize_bad = line_end && (pix_cnt != {1'b0, IMG_HDISP});
    assign vsize_bad = (state_q == S_CHECK) && (line_cnt != {1'b0, IMG_VDISP});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_cnt  <= 11'd0;
            line_cnt <= 11'd0;
        end else if (cnt_clr) begin
            pix_cnt  <= 11'd0;
            line_cnt <= 11'd0;
        end else if (state_q == S_ACTIVE) begin
            if (line_end) begin
                pix_cnt <= 11'd0;
                if (line_cnt != 11'h7FF) line_cnt <= line_cnt + 11'd1;
            end else if (bus.post_frame_href && bus.post_frame_clken && (pix_cnt != 11'h7FF)) begin
                pix_cnt <= pix_cnt + 11'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_h_q <= 1'b0;
            err_v_q <= 1'b0;
        end else if (bus.err_clr) begin
            err_h_q <= 1'b0;
            err_v_q <= 1'b0;
        end else begin
            if (hsize_bad) err_h_q <= 1'b1;
            if (vsize_bad) err_v_q <= 1'b1;
        end
    end

`ifdef VIP_FRAME_CTRL_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  frame_cnt_q <= 16'd0;
        else if (state_q == S_CHECK) frame_cnt_q <= frame_cnt_q + 16'd1;
    end
    assign bus.frame_cnt = frame_cnt_q;
`else
    assign bus.frame_cnt = 16'd0;
`endif

    assign bus.cfg_ack        = ack_q;
    assign bus.cfg_busy       = busy_q;
    assign bus.in_mode        = in_mode_q;
    assign bus.out_sel        = out_sel_q;
    assign bus.frame_done     = (state_q == S_CHECK);
    assign bus.err_hsize      = err_h_q;
    assign bus.err_vsize      = err_v_q;
    assign bus.dbg_meas_state = state_q;
endmodule
